// File: rtl/aip_slave_if.sv
// Accelerator-side AIP slave: host buffers, config/status registers and the core start/done handshake.
// Optional feature macro: AIP_IF_IRQ_EN (interrupt-enable register and completion interrupt).
module aip_slave_if #(
  parameter int          MEM_AW = 4,
  parameter logic [31:0] IP_ID  = 32'h0000_A1B0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [31:0]       i_aip_dataIn,
  input  logic [4:0]        i_aip_config,
  input  logic              i_aip_read,
  input  logic              i_aip_write,
  input  logic              i_aip_start,
  output logic [31:0]       o_aip_dataOut,
  output logic              o_aip_int,
  output logic              o_core_start,
  input  logic              i_core_done,
  output logic [31:0]       o_core_cfg,
  input  logic [MEM_AW-1:0] i_core_in_addr,
  output logic [31:0]       o_core_in_rdata,
  input  logic              i_core_out_we,
  input  logic [MEM_AW-1:0] i_core_out_addr,
  input  logic [31:0]       i_core_out_wdata
);

  localparam int DEPTH = 1 << MEM_AW;
  localparam logic [4:0] SEL_MEMIN  = 5'h00;
  localparam logic [4:0] SEL_MEMOUT = 5'h01;
  localparam logic [4:0] SEL_CONF   = 5'h02;
  localparam logic [4:0] SEL_STATUS = 5'h1E;
  localparam logic [4:0] SEL_ID     = 5'h1F;
  localparam logic [MEM_AW-1:0] PTR_ONE = {{(MEM_AW-1){1'b0}}, 1'b1};
  localparam logic [MEM_AW-1:0] PTR_ZERO = {MEM_AW{1'b0}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_read_q;
  logic              r_write_q;
  logic              r_start_q;
  logic [4:0]        r_sel_q;
  logic [MEM_AW-1:0] r_wptr;
  logic [MEM_AW-1:0] r_rptr;
  logic [31:0]       r_cfg;
  logic              r_core_start;
  logic              r_int;
  logic [31:0]       r_mem_in  [DEPTH];
  logic [31:0]       r_mem_out [DEPTH];

  logic        w_rd_edge;
  logic        w_wr_edge;
  logic        w_start_edge;
  logic        w_sel_chg;
  logic        w_status_wr;
  logic        w_status_clr;
  logic        w_start_acc;
  logic        w_busy;
  logic        w_done;
  logic        w_int_en;
  logic        w_int_en_nxt;
  logic [31:0] w_rdata;

  // One action per rising strobe, however long the bridge holds it.
  assign w_rd_edge    = i_aip_read  & ~r_read_q;
  assign w_wr_edge    = i_aip_write & ~r_write_q;
  assign w_start_edge = i_aip_start & ~r_start_q;
  assign w_sel_chg    = (i_aip_config != r_sel_q);
  assign w_status_wr  = w_wr_edge & (i_aip_config == SEL_STATUS);
  assign w_status_clr = w_status_wr & i_aip_dataIn[0];
  assign w_busy       = (r_state == S_RUN);
  assign w_done       = (r_state == S_DONE);

`ifdef AIP_IF_IRQ_EN
  logic r_int_en;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_int_en <= 1'b0;
    end else if (w_status_wr) begin
      r_int_en <= i_aip_dataIn[16];
    end
  end

  assign w_int_en     = r_int_en;
  assign w_int_en_nxt = w_status_wr ? i_aip_dataIn[16] : r_int_en;
`else
  assign w_int_en     = 1'b0;
  assign w_int_en_nxt = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_read_q  <= 1'b0;
      r_write_q <= 1'b0;
      r_start_q <= 1'b0;
      r_sel_q   <= 5'h00;
    end else begin
      r_read_q  <= i_aip_read;
      r_write_q <= i_aip_write;
      r_start_q <= i_aip_start;
      r_sel_q   <= i_aip_config;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt = S_RUN;
          w_start_acc = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      // A STATUS clear landing together with core done loses: done still sets.
      S_RUN: begin
        if (i_core_done) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DONE: begin
        if (w_start_edge) begin
          w_state_nxt = S_RUN;
          w_start_acc = 1'b1;
        end else if (w_status_clr) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_core_start <= 1'b0;
      r_int        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_core_start <= w_start_acc;
      r_int        <= (w_state_nxt == S_DONE) & w_int_en_nxt;
    end
  end

  // Target switch or a new job rewinds both host pointers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_wptr <= PTR_ZERO;
      r_rptr <= PTR_ZERO;
    end else if (w_sel_chg || w_start_acc) begin
      r_wptr <= PTR_ZERO;
      r_rptr <= PTR_ZERO;
    end else begin
      if (w_wr_edge && (i_aip_config == SEL_MEMIN)) begin
        r_wptr <= r_wptr + PTR_ONE;
      end
      if (w_rd_edge && ((i_aip_config == SEL_MEMIN) || (i_aip_config == SEL_MEMOUT))) begin
        r_rptr <= r_rptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_cfg <= 32'h0000_0000;
    end else if (w_wr_edge && (i_aip_config == SEL_CONF)) begin
      r_cfg <= i_aip_dataIn;
    end
  end

  // Buffer contents are deliberately left unreset.
  always_ff @(posedge i_clk) begin
    if (w_wr_edge && (i_aip_config == SEL_MEMIN)) begin
      r_mem_in[r_wptr] <= i_aip_dataIn;
    end
    if (i_core_out_we) begin
      r_mem_out[i_core_out_addr] <= i_core_out_wdata;
    end
  end

  always_comb begin
    w_rdata = 32'h0000_0000;
    case (i_aip_config)
      SEL_MEMIN:  w_rdata = r_mem_in[r_rptr];
      SEL_MEMOUT: w_rdata = r_mem_out[r_rptr];
      SEL_CONF:   w_rdata = r_cfg;
      SEL_STATUS: w_rdata = {15'h0000, w_int_en, 14'h0000, w_done, w_busy};
      SEL_ID:     w_rdata = IP_ID;
      default:    w_rdata = 32'h0000_0000;
    endcase
  end

  assign o_aip_dataOut   = w_rdata;
  assign o_aip_int       = r_int;
  assign o_core_start    = r_core_start;
  assign o_core_cfg      = r_cfg;
  assign o_core_in_rdata = r_mem_in[i_core_in_addr];

endmodule

// File: tb/tb_aip_slave_if.sv
// Self-checking bench for aip_slave_if: directed sequence with random data against a behavioural model.
module tb_aip_slave_if;
  localparam int          AW    = 4;
  localparam int          DEPTH = 16;
  localparam logic [31:0] ID    = 32'h0000_A1B0;
`ifdef AIP_IF_IRQ_EN
  localparam bit IRQ = 1'b1;
`else
  localparam bit IRQ = 1'b0;
`endif

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [31:0]   i_aip_dataIn;
  logic [4:0]    i_aip_config;
  logic          i_aip_read;
  logic          i_aip_write;
  logic          i_aip_start;
  logic [31:0]   o_aip_dataOut;
  logic          o_aip_int;
  logic          o_core_start;
  logic          i_core_done;
  logic [31:0]   o_core_cfg;
  logic [AW-1:0] i_core_in_addr;
  logic [31:0]   o_core_in_rdata;
  logic          i_core_out_we;
  logic [AW-1:0] i_core_out_addr;
  logic [31:0]   i_core_out_wdata;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_in  [DEPTH];
  logic [31:0] m_out [DEPTH];
  int          m_wptr;
  int          m_rptr;
  logic [31:0] m_cfg;
  logic [4:0]  m_sel;
  bit          m_int_en;
  bit          m_busy;
  bit          m_done;

  aip_slave_if #(.MEM_AW(AW), .IP_ID(ID)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_aip_dataIn(i_aip_dataIn), .i_aip_config(i_aip_config),
    .i_aip_read(i_aip_read), .i_aip_write(i_aip_write), .i_aip_start(i_aip_start),
    .o_aip_dataOut(o_aip_dataOut), .o_aip_int(o_aip_int), .o_core_start(o_core_start),
    .i_core_done(i_core_done), .o_core_cfg(o_core_cfg), .i_core_in_addr(i_core_in_addr),
    .o_core_in_rdata(o_core_in_rdata), .i_core_out_we(i_core_out_we),
    .i_core_out_addr(i_core_out_addr), .i_core_out_wdata(i_core_out_wdata)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] m_status();
    return {15'h0000, m_int_en, 14'h0000, m_done, m_busy};
  endfunction

  function automatic logic [31:0] m_rdata();
    case (m_sel)
      5'h00:   return m_in[m_rptr];
      5'h01:   return m_out[m_rptr];
      5'h02:   return m_cfg;
      5'h1E:   return m_status();
      5'h1F:   return ID;
      default: return 32'h0000_0000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic m_reset();
    m_wptr = 0; m_rptr = 0; m_cfg = 32'h0; m_int_en = 1'b0; m_busy = 1'b0; m_done = 1'b0;
  endtask

  task automatic set_sel(input logic [4:0] sel);
    if (sel != m_sel) begin
      m_wptr = 0;
      m_rptr = 0;
    end
    m_sel = sel;
    i_aip_config = sel;
    tick();
  endtask

  task automatic host_wr(input logic [31:0] data, input int hold);
    i_aip_dataIn = data;
    i_aip_write  = 1'b1;
    repeat (hold) tick();
    i_aip_write  = 1'b0;
    tick();
    case (m_sel)
      5'h00: begin
        m_in[m_wptr] = data;
        m_wptr = (m_wptr + 1) % DEPTH;
      end
      5'h02: m_cfg = data;
      5'h1E: begin
        if (IRQ) m_int_en = data[16];
        if (data[0]) m_done = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic host_rd(input int hold);
    chk("host_read_data", o_aip_dataOut, m_rdata());
    i_aip_read = 1'b1;
    repeat (hold) tick();
    i_aip_read = 1'b0;
    tick();
    if (m_sel == 5'h00 || m_sel == 5'h01) m_rptr = (m_rptr + 1) % DEPTH;
  endtask

  task automatic start_edge();
    bit acc;
    acc = !m_busy;
    i_aip_start = 1'b1;
    tick();
    if (acc) begin
      m_busy = 1'b1; m_done = 1'b0; m_wptr = 0; m_rptr = 0;
    end
    chk("start_pulse", {31'h0, o_core_start}, {31'h0, acc});
    tick();
    chk("start_pulse_len", {31'h0, o_core_start}, 32'h0);
    i_aip_start = 1'b0;
    tick();
  endtask

  task automatic core_done_pulse();
    i_core_done = 1'b1;
    tick();
    i_core_done = 1'b0;
    if (m_busy) begin
      m_busy = 1'b0;
      m_done = 1'b1;
    end
  endtask

  task automatic chk_status(input string tag);
    chk(tag, o_aip_dataOut, m_status());
    chk({tag, "_int"}, {31'h0, o_aip_int}, {31'h0, m_done & m_int_en});
  endtask

  initial begin
    logic [31:0] d;
    i_rst = 1'b0; i_aip_dataIn = 32'h0; i_aip_config = 5'h1F; i_aip_read = 1'b0;
    i_aip_write = 1'b0; i_aip_start = 1'b0; i_core_done = 1'b0; i_core_in_addr = '0;
    i_core_out_we = 1'b0; i_core_out_addr = '0; i_core_out_wdata = 32'h0;
    m_reset();
    m_sel = 5'h1F;
    repeat (3) tick();
    chk("reset_id", o_aip_dataOut, m_rdata());
    chk("reset_int", {31'h0, o_aip_int}, 32'h0);
    chk("reset_start", {31'h0, o_core_start}, 32'h0);
    chk("reset_cfg", o_core_cfg, 32'h0);
    i_aip_config = 5'h1E;
    m_sel = 5'h1E;
    #1;
    chk("reset_status", o_aip_dataOut, m_rdata());
    i_rst = 1'b1;
    tick();

    // Input buffer: 18 writes wrap over the 16-entry buffer.
    set_sel(5'h00);
    for (int i = 1; i <= 18; i++) host_wr(i, 3);
    for (int a = 0; a < DEPTH; a++) begin
      i_core_in_addr = a[AW-1:0];
      #1;
      chk("core_in_rd", o_core_in_rdata, m_in[a]);
    end

    // Random writes then host read-back after a pointer rewind.
    set_sel(5'h1F);
    set_sel(5'h00);
    for (int i = 0; i < 5; i++) host_wr($urandom, 1 + int'($urandom_range(2)));
    set_sel(5'h1F);
    set_sel(5'h00);
    for (int i = 0; i < 6; i++) host_rd(2);

    // Config register.
    set_sel(5'h02);
    host_wr(32'hDEAD_BEEF, 2);
    chk("core_cfg", o_core_cfg, m_cfg);
    chk("cfg_readback", o_aip_dataOut, m_rdata());
    host_wr($urandom, 1);
    chk("core_cfg_rand", o_core_cfg, m_cfg);

    // Undefined and ID targets ignore writes and read as 0 / ID.
    set_sel(5'h05);
    host_wr($urandom, 1);
    chk("undef_read", o_aip_dataOut, m_rdata());
    chk("undef_cfg", o_core_cfg, m_cfg);

    // Start / busy / done handshake.
    set_sel(5'h1E);
    host_wr(32'h0001_0000, 1);
    chk_status("status_inten");
    start_edge();
    chk_status("status_busy");
    start_edge();
    chk_status("status_busy2");
    core_done_pulse();
    chk_status("status_done");
    host_wr(32'h0001_0001, 1);
    chk_status("status_clear");
    core_done_pulse();
    chk_status("done_in_idle");

    // DONE -> RUN via a new start, then clear and done together.
    start_edge();
    core_done_pulse();
    chk_status("done_again");
    start_edge();
    chk_status("restart_from_done");
    i_aip_dataIn = 32'h0001_0001;
    i_aip_write  = 1'b1;
    i_core_done  = 1'b1;
    tick();
    i_aip_write  = 1'b0;
    i_core_done  = 1'b0;
    if (IRQ) m_int_en = 1'b1;
    m_busy = 1'b0;
    m_done = 1'b1;
    tick();
    chk_status("done_wins");
    host_wr(32'h0000_0001, 1);
    chk_status("clear_no_inten");

    // Output buffer filled by the core, read by the host.
    for (int k = 0; k < 4; k++) begin
      d = $urandom;
      i_core_out_we = 1'b1;
      i_core_out_addr = k[AW-1:0];
      i_core_out_wdata = d;
      m_out[k] = d;
      tick();
    end
    i_core_out_we = 1'b0;
    set_sel(5'h01);
    for (int k = 0; k < 4; k++) host_rd(2);
    set_sel(5'h00);
    set_sel(5'h01);
    chk("memout_rewind", o_aip_dataOut, m_out[0]);
    d = $urandom;
    i_core_out_we = 1'b1;
    i_core_out_addr = '0;
    i_core_out_wdata = d;
    #1;
    chk("memout_old_data", o_aip_dataOut, m_out[0]);
    tick();
    i_core_out_we = 1'b0;
    m_out[0] = d;
    chk("memout_new_data", o_aip_dataOut, m_out[0]);

    // Reset while running.
    set_sel(5'h1E);
    host_wr(32'h0001_0000, 1);
    start_edge();
    chk_status("pre_reset_busy");
    i_rst = 1'b0;
    #2;
    m_reset();
    chk_status("reset_mid_run");
    chk("reset_mid_cfg", o_core_cfg, 32'h0);
    tick();
    i_rst = 1'b1;
    tick();
    core_done_pulse();
    tick();
    chk_status("done_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
